// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed 7-segment scanner with PWM brightness window.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_EN.
module seg_scan_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [15:0] digit,
    input  logic [2:0]  bright,
    output logic [3:0]  scathod,
    output logic [6:0]  ssegment
);
    localparam int          PRE_W = $clog2(SCAN_DIV);
    localparam int unsigned SLICE = SCAN_DIV / 8;

    logic [PRE_W-1:0] pre;
    logic [1:0]       idx;
    logic [15:0]      shd;
    logic [15:0]      shd_nxt;
    logic             pre_wrap;
    logic             load;
    logic             lit;
    logic             blank;
    logic [3:0]       nib;
    logic [31:0]      win_end;
    logic [3:0]       sel_nxt;
    logic [6:0]       seg_nxt;

    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        case (h)
            4'h0: hex_decode = 7'b1000000;
            4'h1: hex_decode = 7'b1111001;
            4'h2: hex_decode = 7'b0100100;
            4'h3: hex_decode = 7'b0110000;
            4'h4: hex_decode = 7'b0011001;
            4'h5: hex_decode = 7'b0010010;
            4'h6: hex_decode = 7'b0000010;
            4'h7: hex_decode = 7'b1111000;
            4'h8: hex_decode = 7'b0000000;
            4'h9: hex_decode = 7'b0010000;
            4'hA: hex_decode = 7'b0001000;
            4'hB: hex_decode = 7'b0000011;
            4'hC: hex_decode = 7'b1000110;
            4'hD: hex_decode = 7'b0100001;
            4'hE: hex_decode = 7'b0000110;
            default: hex_decode = 7'b0001110;
        endcase
    endfunction

    assign pre_wrap = (pre == PRE_W'(SCAN_DIV - 1));
    assign load     = (pre == '0) && (idx == 2'd0);
    // Decode from the value being loaded this cycle so slot 0's first
    // lit cycle already shows the new frame.
    assign shd_nxt  = load ? digit : shd;
    assign nib      = shd_nxt[{idx, 2'b00} +: 4];
    assign win_end  = (32'(bright) + 32'd1) * SLICE;
    assign lit      = (32'(pre) < win_end);

`ifdef SEG_BLANK_EN
    logic [3:0] lead_zero;
    always_comb begin
        lead_zero = '0;
        for (int n = 1; n < 4; n++)
            lead_zero[n] = ((shd_nxt >> (4 * n)) == 16'h0000);
    end
    assign blank = lead_zero[idx];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        sel_nxt = 4'b1111;
        seg_nxt = 7'b1111111;
        if (lit && !blank) begin
            sel_nxt = ~(4'b0001 << idx);
            seg_nxt = hex_decode(nib);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pre      <= '0;
            idx      <= 2'd0;
            shd      <= 16'h0000;
            scathod  <= 4'b1111;
            ssegment <= 7'b1111111;
        end else begin
            pre      <= pre_wrap ? '0 : pre + 1'b1;
            if (pre_wrap)
                idx <= idx + 2'd1;
            shd      <= shd_nxt;
            scathod  <= sel_nxt;
            ssegment <= seg_nxt;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at SCAN_DIV=8 (one frame = 32 cycles).
module tb_seg_scan_driver;
    logic        sys_clk = 1'b0;
    logic        rst;
    logic [15:0] digit;
    logic [2:0]  bright;
    logic [3:0]  scathod;
    logic [6:0]  ssegment;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(.SCAN_DIV(8)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .digit    (digit),
        .bright   (bright),
        .scathod  (scathod),
        .ssegment (ssegment)
    );

    always #5 sys_clk = ~sys_clk;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S7 = 7'b1111000, S8 = 7'b0000000, SA = 7'b0001000,
                           SC = 7'b1000110, SD = 7'b0100001, SE = 7'b0000110,
                           OFF = 7'b1111111;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One slot of 8 cycles: lit for the first lit_n cycles unless dark.
    task automatic check_slot(input string tag, input int s, input logic [6:0] seg,
                              input logic dark, input int lit_n);
        logic [3:0] sel;
        sel = 4'b1111;
        sel[s] = 1'b0;
        for (int p = 0; p < 8; p++) begin
            tick();
            if (p < lit_n && !dark) begin
                chk({tag, "_sel"}, 32'(scathod), 32'(sel));
                chk({tag, "_seg"}, 32'(ssegment), 32'(seg));
            end else begin
                chk({tag, "_sel_off"}, 32'(scathod), 32'hF);
                chk({tag, "_seg_off"}, 32'(ssegment), 32'(OFF));
            end
        end
    endtask

    initial begin
        logic dark_hi;
        int   low_cnt;
        rst = 1'b1; digit = 16'h1234; bright = 3'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_sel", 32'(scathod), 32'hF);
            chk("rst_seg", 32'(ssegment), 32'(OFF));
        end
        rst = 1'b0;

        // Full brightness, 1234 shown as 4,3,2,1 by position.
        check_slot("f1234_p0", 0, S4, 1'b0, 8);
        check_slot("f1234_p1", 1, S3, 1'b0, 8);
        check_slot("f1234_p2", 2, S2, 1'b0, 8);
        check_slot("f1234_p3", 3, S1, 1'b0, 8);

        // Dimmest setting: exactly one lit cycle per slot.
        bright = 3'd0; digit = 16'h0008;
`ifdef SEG_BLANK_EN
        dark_hi = 1'b1;
`else
        dark_hi = 1'b0;
`endif
        low_cnt = 0;
        for (int p = 0; p < 8; p++) begin
            tick();
            if (scathod != 4'b1111) begin
                low_cnt++;
                chk("dim_p0_seg", 32'(ssegment), 32'(S8));
            end
        end
        chk("dim_p0_lowcnt", 32'(low_cnt), 32'd1);
        check_slot("dim_p1", 1, S0, dark_hi, 1);
        check_slot("dim_p2", 2, S0, dark_hi, 1);
        check_slot("dim_p3", 3, S0, dark_hi, 1);

        // Mid-frame input change must wait for the next frame load.
        bright = 3'd7; digit = 16'hAAAA;
        check_slot("aa_p0", 0, SA, 1'b0, 8);
        check_slot("aa_p1", 1, SA, 1'b0, 8);
        digit = 16'h5555;
        check_slot("aa_p2", 2, SA, 1'b0, 8);
        check_slot("aa_p3", 3, SA, 1'b0, 8);
        check_slot("55_p0", 0, S5, 1'b0, 8);
        check_slot("55_p1", 1, S5, 1'b0, 8);
        check_slot("55_p2", 2, S5, 1'b0, 8);
        check_slot("55_p3", 3, S5, 1'b0, 8);

        // Leading zeros (dark only when blanking is built in).
        digit = 16'h0070;
        check_slot("lz_p0", 0, S0, 1'b0, 8);
        check_slot("lz_p1", 1, S7, 1'b0, 8);
        check_slot("lz_p2", 2, S0, dark_hi, 8);
        check_slot("lz_p3", 3, S0, dark_hi, 8);

        // Reset pulse at idx=2, pre=5, then a fresh frame.
        for (int i = 0; i < 21; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_sel", 32'(scathod), 32'hF);
        chk("mid_rst_seg", 32'(ssegment), 32'(OFF));
        rst = 1'b0; digit = 16'hC0DE;
        check_slot("c0de_p0", 0, SE, 1'b0, 8);
        check_slot("c0de_p1", 1, SD, 1'b0, 8);
        check_slot("c0de_p2", 2, S0, 1'b0, 8);
        check_slot("c0de_p3", 3, SC, 1'b0, 8);

        // Random inputs: at most one position selected on every cycle.
        for (int i = 0; i < 320; i++) begin
            digit  = 16'($urandom);
            bright = 3'($urandom_range(0, 7));
            tick();
            chk("onehot", 32'($countones(~scathod) <= 1), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000: sys_clk cycles per digit slot; SHALL be a multiple of 8 and at least 8.
REQ-002 sys_clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 digit  input  16  four hex nibbles from the counter chain; digit[3:0] is the rightmost display position (position 0).
REQ-005 bright  input  3  brightness level: 0 is dimmest, 7 is full on.
REQ-006 scathod  output  4  digit select, active-low, one-hot-or-none; bit n drives position n.
REQ-007 ssegment  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-008 Prescaler pre SHALL count 0..SCAN_DIV-1 and then wrap to 0.
REQ-009 Slot index idx (2 bits) SHALL advance 0->1->2->3->0 on the cycle where pre wraps.
REQ-010 Shadow register shd SHALL load digit on every cycle where pre==0 and idx==0, and SHALL hold at all other times, so that a frame never mixes two input values.
REQ-011 Lit window: the current slot SHALL be lit while pre < (bright+1)*(SCAN_DIV/8). Outside the window, scathod SHALL be 4'b1111 and ssegment SHALL be 7'b1111111.
REQ-012 While the slot is lit, scathod SHALL equal ~(4'b0001<<idx), and ssegment SHALL be the hex decode of shd[4*idx+3:4*idx].
REQ-013 Hex decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-014 scathod and ssegment SHALL be registered outputs, lagging (pre, idx) by exactly one cycle.
REQ-015 bright=7 SHALL keep the slot lit for the whole slot; no bright value SHALL produce a zero-width window.
REQ-016 A change on bright SHALL take effect on the next cycle's window compare; no latching is required.
REQ-017 A change on digit during a frame SHALL not alter outputs until the next pre==0, idx==0 load.
REQ-018 Any two positions SHALL never be selected at the same time; scathod SHALL be one-hot-low or all-ones on every cycle.

Reset
REQ-019 While rst is high on a clock edge, the block SHALL set pre=0, idx=0, shd=16'h0000, scathod=4'b1111 and ssegment=7'b1111111.
REQ-020 On the first edge after rst deasserts, shd SHALL load digit (pre==0, idx==0).
REQ-021 Assertion of rst mid-slot or mid-frame SHALL take priority over all other updates in that cycle.

Configuration
REQ-022 Macro SEG_BLANK_EN:
- Defined: leading-zero blanking is enabled. Position n (n=3,2,1) SHALL be dark (scathod 4'b1111, ssegment 7'b1111111) during its lit window when shd nibbles n..3 are all zero. Position 0 SHALL never be blanked.
- Undefined: every position SHALL display its nibble, including leading zeros. Blanking logic SHALL be absent.

Verification (SCAN_DIV=8)
REQ-023 rst high for 3 cycles, then digit=16'h1234, bright=7:
- after rst: scathod=1111, ssegment=1111111;
- then position 0 shows 4 (0011001, scathod 1110) for 8 cycles;
- then positions 1, 2, 3 show 3, 2, 1 in turn, one slot each.
REQ-024 bright=0, digit=16'h0008: scathod is low for exactly 1 of 8 cycles per slot; in that cycle, position 0 shows ssegment 0000000.
REQ-025 digit changes from 16'hAAAA to 16'h5555 while idx=2: positions 2 and 3 still show A (0001000); 5 (0010010) appears only from the next idx=0 slot.
REQ-026 SEG_BLANK_EN defined, digit=16'h0070:
- positions 3 and 2 stay dark;
- position 1 shows 7 (1111000);
- position 0 shows 0 (1000000).
With the macro undefined, positions 3 and 2 show 0 instead.
REQ-027 rst pulsed for one cycle at idx=2, pre=5: outputs go to all-ones on the next edge, and scanning restarts at idx=0 with a fresh shd load.
REQ-028 Over 10 full frames with random digit and bright values, scathod never has more than one bit low.
